// File: rtl/fxp_divider_if.sv
// Handshake and operand/result bundle for fxp_divider.
// The master side issues operands and consumes results.
interface fxp_divider_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic             is_signed;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] d;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             dbz;
   logic             ovf;

   modport master (
      output in_valid, is_signed, n, d, out_ready,
      input  in_ready, out_valid, q, r, dbz, ovf
   );

   modport slave (
      input  in_valid, is_signed, n, d, out_ready,
      output in_ready, out_valid, q, r, dbz, ovf
   );
endinterface

// File: rtl/fxp_divider.sv
// Iterative fixed-point divider with a valid/ready handshake on both sides.
// It works on magnitudes, retiring BITS_PER_CYCLE restoring-division quotient
// bits per clock. One extra cycle applies the sign, saturation and
// divide-by-zero rules. Latency is fixed at ITER+1 clocks after accept.
module fxp_divider #(
   parameter int WIDTH          = 32,
   parameter int FBITS          = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic          clk,
   input logic          rst,
   fxp_divider_if.slave bus
);
   localparam int          DW   = WIDTH + FBITS;
   localparam int          ITER = (DW + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int          TOT  = ITER * BITS_PER_CYCLE;
   localparam int          CW   = $clog2(ITER + 1);
   localparam int unsigned BPC  = BITS_PER_CYCLE;

   localparam logic [DW:0]      LIM_N = (DW+1)'(1) << (WIDTH - 1);
   localparam logic [DW:0]      LIM_P = LIM_N - (DW+1)'(1);
   localparam logic [DW:0]      LIM_U = (LIM_N << 1) - (DW+1)'(1);
   localparam logic [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nx;
   logic             accept, iterate, finish;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dmag, rem, rem_nx;
   logic [TOT-1:0]   sr, sr_nx;
   logic [DW-1:0]    quo, quo_nx;
   logic [WIDTH:0]   trial;
   logic             rsign, nneg, sgn;
   logic [WIDTH-1:0] nmag_in, dmag_in;
   logic [DW:0]      qx;
   logic [WIDTH-1:0] q_fin, r_fin;
   logic             ovf_fin, dbz_fin;
   logic [WIDTH-1:0] q_r, r_r;
   logic             dbz_r, ovf_r;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and handshake outputs. DONE with out_ready behaves like IDLE,
   // so a waiting operand is accepted on the same edge the result retires.
   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      iterate       = 1'b0;
      finish        = 1'b0;
      case (state)
         IDLE: bus.in_ready = !rst;
         CALC: begin
            if (cnt != '0) begin
               iterate = 1'b1;
            end else begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.in_ready  = !rst && bus.out_ready;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      accept = bus.in_valid && bus.in_ready;
      if (accept) state_nx = CALC;
   end

   // Operand magnitudes; the most negative value maps to its exact magnitude
   always_comb begin
      nmag_in = (bus.is_signed && bus.n[WIDTH-1]) ? -bus.n : bus.n;
      dmag_in = (bus.is_signed && bus.d[WIDTH-1]) ? -bus.d : bus.d;
   end

   // One clock of restoring division: BPC shift/compare/subtract steps
   always_comb begin
      rem_nx = rem;
      sr_nx  = sr;
      quo_nx = quo;
      trial  = '0;
      for (int unsigned i = 0; i < BPC; i++) begin
         trial = {rem_nx, sr_nx[TOT-1]};
         sr_nx = sr_nx << 1;
         if (trial >= {1'b0, dmag}) begin
            trial  = trial - {1'b0, dmag};
            quo_nx = {quo_nx[DW-2:0], 1'b1};
         end else begin
            quo_nx = {quo_nx[DW-2:0], 1'b0};
         end
         rem_nx = trial[WIDTH-1:0];
      end
   end

   // Final result: divide-by-zero, then saturation, then signed fix-up
   always_comb begin
      qx      = {1'b0, quo};
      dbz_fin = (dmag == '0);
      ovf_fin = 1'b0;
      q_fin   = rsign ? -quo[WIDTH-1:0] : quo[WIDTH-1:0];
      r_fin   = nneg ? -rem : rem;
      if (dbz_fin) begin
         r_fin = '0;
         q_fin = !sgn ? '1 : (nneg ? SMIN : SMAX);
      end else if (sgn && !rsign && qx > LIM_P) begin
         q_fin   = SMAX;
         r_fin   = '0;
         ovf_fin = 1'b1;
      end else if (sgn && rsign && qx > LIM_N) begin
         q_fin   = SMIN;
         r_fin   = '0;
         ovf_fin = 1'b1;
      end else if (!sgn && qx > LIM_U) begin
         q_fin   = '1;
         r_fin   = '0;
         ovf_fin = 1'b1;
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, register the result
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         dmag  <= '0;
         rem   <= '0;
         sr    <= '0;
         quo   <= '0;
         rsign <= 1'b0;
         nneg  <= 1'b0;
         sgn   <= 1'b0;
         q_r   <= '0;
         r_r   <= '0;
         dbz_r <= 1'b0;
         ovf_r <= 1'b0;
      end else if (accept) begin
         dmag  <= dmag_in;
         sr    <= TOT'(nmag_in) << FBITS;
         rem   <= '0;
         quo   <= '0;
         sgn   <= bus.is_signed;
         nneg  <= bus.is_signed & bus.n[WIDTH-1];
         rsign <= bus.is_signed & (bus.n[WIDTH-1] ^ bus.d[WIDTH-1]);
         cnt   <= CW'(ITER);
      end else if (iterate) begin
         rem <= rem_nx;
         sr  <= sr_nx;
         quo <= quo_nx;
         cnt <= cnt - 1'b1;
      end else if (finish) begin
         q_r   <= q_fin;
         r_r   <= r_fin;
         dbz_r <= dbz_fin;
         ovf_r <= ovf_fin;
      end
   end

   assign bus.q   = q_r;
   assign bus.r   = r_r;
   assign bus.dbz = dbz_r;
   assign bus.ovf = ovf_r;
endmodule

// File: tb/tb_fxp_divider.sv
// Scoreboard bench for fxp_divider. It runs a 1-bit/cycle and a 4-bit/cycle
// instance one after the other, against a plain-arithmetic reference model.
module tb_fxp_divider;
   localparam int W = 32;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
      int          acc;
   } exp_t;

   typedef struct {
      bit          s;
      logic [31:0] n, d, q, r;
      bit          dbz, ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        in_valid, is_signed, out_ready;
   logic [31:0] n, d;
   bit          bp_rand;
   int          cyc = 0;
   int          checks = 0;
   int          errs = 0;
   exp_t        sb[$];
   vec_t        dirq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fxp_divider_if #(.WIDTH(W)) if1 ();
   fxp_divider_if #(.WIDTH(W)) if4 ();

   assign if1.in_valid  = in_valid & ~sel;
   assign if1.is_signed = is_signed;
   assign if1.n         = n;
   assign if1.d         = d;
   assign if1.out_ready = out_ready;
   assign if4.in_valid  = in_valid & sel;
   assign if4.is_signed = is_signed;
   assign if4.n         = n;
   assign if4.d         = d;
   assign if4.out_ready = out_ready;

   fxp_divider #(.WIDTH(32), .FBITS(16), .BITS_PER_CYCLE(1)) u_div1 (
      .clk(clk), .rst(rst), .bus(if1));
   fxp_divider #(.WIDTH(32), .FBITS(16), .BITS_PER_CYCLE(4)) u_div4 (
      .clk(clk), .rst(rst), .bus(if4));

   logic        in_ready_m, out_valid_m, dbz_m, ovf_m;
   logic [31:0] q_m, r_m;
   int          iter_m;
   assign in_ready_m  = sel ? if4.in_ready  : if1.in_ready;
   assign out_valid_m = sel ? if4.out_valid : if1.out_valid;
   assign dbz_m       = sel ? if4.dbz       : if1.dbz;
   assign ovf_m       = sel ? if4.ovf       : if1.ovf;
   assign q_m         = sel ? if4.q         : if1.q;
   assign r_m         = sel ? if4.r         : if1.r;
   assign iter_m      = sel ? 12 : 48;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s sel=%0d cyc=%0d: got %h expected %h", name, sel, cyc, got, exp);
      end
   endtask

   // Reference: exact integer arithmetic on magnitudes, then the result rules
   function automatic exp_t model(input bit s, input logic [31:0] nn, input logic [31:0] dd);
      exp_t e;
      longint unsigned nm, dm, dv, qq, rr;
      bit nneg, neg;
      nneg = s && nn[31];
      neg  = s && (nn[31] ^ dd[31]);
      nm = nneg ? 64'h1_0000_0000 - {32'd0, nn} : {32'd0, nn};
      dm = (s && dd[31]) ? 64'h1_0000_0000 - {32'd0, dd} : {32'd0, dd};
      e.acc = 0; e.dbz = 1'b0; e.ovf = 1'b0; e.r = '0; e.q = '0;
      if (dm == 0) begin
         e.dbz = 1'b1;
         e.q = !s ? 32'hFFFF_FFFF : (nn[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      end else begin
         dv = nm << 16;
         qq = dv / dm;
         rr = dv % dm;
         if (s && !neg && qq > 64'h7FFF_FFFF) begin
            e.q = 32'h7FFF_FFFF; e.ovf = 1'b1;
         end else if (s && neg && qq > 64'h8000_0000) begin
            e.q = 32'h8000_0000; e.ovf = 1'b1;
         end else if (!s && qq > 64'hFFFF_FFFF) begin
            e.q = 32'hFFFF_FFFF; e.ovf = 1'b1;
         end else begin
            e.q = neg  ? 32'(64'd0 - qq) : 32'(qq);
            e.r = nneg ? 32'(64'd0 - rr) : 32'(rr);
         end
      end
      return e;
   endfunction

   function automatic exp_t vexp(input vec_t v);
      exp_t e;
      e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.ovf = v.ovf; e.acc = 0;
      return e;
   endfunction

   function automatic vec_t mk(input bit s, input logic [31:0] nn, input logic [31:0] dd,
                               input logic [31:0] qq, input logic [31:0] rr,
                               input bit z, input bit o);
      vec_t v;
      v.s = s; v.n = nn; v.d = dd; v.q = qq; v.r = rr; v.dbz = z; v.ovf = o;
      return v;
   endfunction

   // Entered just after a rising edge; returns just after the accepting edge
   task automatic send(input bit s, input logic [31:0] nn, input logic [31:0] dd,
                       input exp_t e, output int waited);
      in_valid  = 1'b1;
      is_signed = s;
      n         = nn;
      d         = dd;
      waited    = 0;
      @(negedge clk);
      while (!in_ready_m && waited < 1000) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready_m) begin
         checks++; errs++;
         $display("FAIL accept_timeout sel=%0d: in_ready got 0 expected 1", sel);
      end else begin
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 5000) begin
         w++;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         checks++; errs++;
         $display("FAIL drain_timeout sel=%0d: pending got %0d expected 0", sel, sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   // Monitor: checks first-valid latency, then pops and compares on handshake
   bit seen = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen = 1'b0;
         end else if (out_valid_m) begin
            if (sb.size() == 0) begin
               if (!seen) chk("unexpected_out_valid", 32'(out_valid_m), 32'd0);
               seen = !out_ready;
            end else begin
               if (!seen) chk("latency", 32'(cyc - sb[0].acc), 32'(iter_m + 1));
               seen = 1'b1;
               if (out_ready) begin
                  e = sb.pop_front();
                  chk("q", q_m, e.q);
                  chk("r", r_m, e.r);
                  chk("dbz", 32'(dbz_m), 32'(e.dbz));
                  chk("ovf", 32'(ovf_m), 32'(e.ovf));
                  seen = 1'b0;
               end
            end
         end
      end
   end

   // Random backpressure on the result side
   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic run_directed();
      int w;
      out_ready = 1'b1;
      foreach (dirq[i]) send(dirq[i].s, dirq[i].n, dirq[i].d, vexp(dirq[i]), w);
      drain();
   endtask

   task automatic run_backpressure();
      int w;
      exp_t a, b;
      a = vexp(dirq[0]);
      b = vexp(dirq[1]);
      out_ready = 1'b0;
      send(dirq[0].s, dirq[0].n, dirq[0].d, a, w);
      w = 0;
      @(negedge clk);
      while (!out_valid_m && w < 200) begin
         w++;
         @(negedge clk);
      end
      chk("bp_out_valid_seen", 32'(out_valid_m), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_q_hold", q_m, a.q);
         chk("bp_r_hold", r_m, a.r);
         chk("bp_flags_hold", {30'd0, dbz_m, ovf_m}, {30'd0, a.dbz, a.ovf});
         chk("bp_in_ready", 32'(in_ready_m), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(dirq[1].s, dirq[1].n, dirq[1].d, b, w);
      chk("b2b_same_edge_accept", 32'(w), 32'd0);
      drain();
   endtask

   task automatic run_reset();
      int w;
      bit vseen;
      out_ready = 1'b1;
      send(1'b0, 32'h0001_0000, 32'h0003_0000, model(1'b0, 32'h0001_0000, 32'h0003_0000), w);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready_low", 32'(in_ready_m), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("abort_out_valid", 32'(out_valid_m), 32'd0);
      chk("abort_q", q_m, 32'd0);
      chk("abort_r", r_m, 32'd0);
      chk("abort_flags", {30'd0, dbz_m, ovf_m}, 32'd0);
      chk("abort_in_ready", 32'(in_ready_m), 32'd1);
      vseen = 1'b0;
      repeat (iter_m + 5) begin
         @(negedge clk);
         if (out_valid_m) vseen = 1'b1;
      end
      chk("abort_no_result", 32'(vseen), 32'd0);
      @(posedge clk); #1;
      send(dirq[3].s, dirq[3].n, dirq[3].d, vexp(dirq[3]), w);
      drain();
   endtask

   task automatic run_random(input int count);
      int w;
      bit s;
      logic [31:0] nn, dd;
      bp_rand = 1'b1;
      for (int i = 0; i < count; i++) begin
         s  = 1'($urandom_range(0, 1));
         nn = $urandom;
         dd = $urandom;
         case ($urandom_range(0, 7))
            0: dd = '0;
            1: begin
               dd = 32'($urandom_range(1, 255));
               if ($urandom_range(0, 1) == 1) dd = -dd;
            end
            2: nn = 32'($urandom_range(0, 65535));
            3: nn = 32'h8000_0000;
            default: ;
         endcase
         send(s, nn, dd, model(s, nn, dd), w);
      end
      bp_rand   = 1'b0;
      out_ready = 1'b1;
      drain();
   endtask

   initial begin
      sel = 1'b0; rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0;
      n = '0; d = '0; out_ready = 1'b1; bp_rand = 1'b0;

      dirq.push_back(mk(1, 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 32'h0, 0, 0));
      dirq.push_back(mk(1, 32'hFFF8_8000, 32'h0002_0000, 32'hFFFC_4000, 32'h0, 0, 0));
      dirq.push_back(mk(0, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 32'h0001_0000, 0, 0));
      dirq.push_back(mk(1, 32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 0, 1));
      dirq.push_back(mk(1, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 32'h0, 1, 0));
      dirq.push_back(mk(0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0));
      dirq.push_back(mk(1, 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0, 0, 1));
      dirq.push_back(mk(1, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h0, 0, 0));
      dirq.push_back(mk(1, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 32'hFFFF_0000, 0, 0));
      dirq.push_back(mk(1, 32'h0004_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0, 1, 0));

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready_m), 32'd0);
      chk("reset_out_valid", {30'd0, if1.out_valid, if4.out_valid}, 32'd0);
      chk("reset_q", q_m | if4.q, 32'd0);
      chk("reset_r", r_m | if4.r, 32'd0);
      chk("reset_flags", {28'd0, if1.dbz, if1.ovf, if4.dbz, if4.ovf}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {30'd0, if1.in_ready, if4.in_ready}, 32'd3);
      @(posedge clk); #1;

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         run_directed();
         run_backpressure();
         run_reset();
         run_random(s == 0 ? 200 : 3000);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
